la_capture_core: RTL and testbench

Parametrised in-fabric logic-analyser capture engine. It is the next generation of the team's GAO debug probe: configurable sample width, trigger width and buffer depth, four trigger modes, and a programmable pre-trigger window. It records `dataIn` into a circular sample RAM around a trigger event on `trigIn`. A host-side or UART readout block then reads samples back in chronological order through a simple indexed read port.

---
 rtl/la_capture_core_pkg.sv | 20 ++
 rtl/la_capture_core_if.sv | 16 +
 rtl/la_capture_core_sample_ram.sv | 29 ++
 rtl/la_capture_core.sv | 139 +++++++++++++
 tb/tb_la_capture_core.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_capture_core_pkg.sv
// Shared types and constants for the logic-analyser capture engine.
// State encodings are visible on captureState, so keep them stable.
package la_capture_pkg;

  localparam int CAPTURE_STATE_W = 3;

  typedef enum logic [CAPTURE_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } capture_state_e;

  localparam logic [1:0] MODE_LEVEL     = 2'd0;
  localparam logic [1:0] MODE_EDGE      = 2'd1;
  localparam logic [1:0] MODE_CHANGE    = 2'd2;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd3;

endpackage

// File: rtl/la_capture_core_if.sv
// Indexed readout port of the capture engine (host side = master).
interface la_capture_core_if #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_W     = 10
);
  // rdEn is a request with no backpressure: a request seen while the core is
  // in DONE returns rdData with rdValid high exactly one cycle later; requests
  // in any other state are dropped (rdValid low, rdData holds its old value).
  logic                  rdEn;
  logic [ADDR_W-1:0]     rdIdx;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;

  modport master (output rdEn, output rdIdx, input rdData, input rdValid);
  modport slave  (input rdEn, input rdIdx, output rdData, output rdValid);
endinterface

// File: rtl/la_capture_core_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the output register resets.
module la_sample_ram #(
  parameter  int DATA_WIDTH = 48,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wrEn,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_W-1:0]     rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)     rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: records dataIn into a circular buffer around
// a trigger on trigIn, then serves the samples oldest-first by logical index.
module la_capture_core import la_capture_pkg::*; #(
  parameter  int DATA_WIDTH = 48,
  parameter  int TRIG_WIDTH = 22,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                       crystalClk,
  input  logic                       rstN,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [1:0]                 trigMode,
  input  logic [TRIG_WIDTH-1:0]      trigValue,
  input  logic [TRIG_WIDTH-1:0]      trigMask,
  input  logic [ADDR_W-1:0]          preTrigDepth,
  input  logic [DATA_WIDTH-1:0]      dataIn,
  input  logic [TRIG_WIDTH-1:0]      trigIn,
  output logic [CAPTURE_STATE_W-1:0] captureState,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic [ADDR_W-1:0]          trigIndex,
  la_capture_core_if.slave           rd
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_PRE   = ST_PRE;
  localparam logic [2:0] S_ARMED = ST_ARMED;
  localparam logic [2:0] S_POST  = ST_POST;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  logic [2:0]            state;
  logic [ADDR_W-1:0]     wrPtr, fill, postLeft, trigAddr, preCfg;
  logic [1:0]            modeCfg;
  logic [TRIG_WIDTH-1:0] valueCfg, maskCfg, trigPrev;
  logic                  writing, armAccept, rdAccept, hit;
  logic                  levelNow, levelPrev, changed;
  logic [ADDR_W-1:0]     rdAddr;

  assign writing   = ((state == S_PRE) || (state == S_ARMED) || (state == S_POST)) && !abort;
  assign armAccept = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign rdAccept  = rd.rdEn && (state == S_DONE);
  // Buffer holds exactly DEPTH samples, the oldest preCfg slots before the trigger.
  assign rdAddr    = trigAddr - preCfg + rd.rdIdx;

  assign levelNow  = ((trigIn   ^ valueCfg) & maskCfg) == '0;
  assign levelPrev = ((trigPrev ^ valueCfg) & maskCfg) == '0;
  assign changed   = |((trigIn ^ trigPrev) & maskCfg);

  always_comb begin
    hit = 1'b0;
    case (modeCfg)
      MODE_LEVEL:  hit = levelNow;
      MODE_EDGE:   hit = levelNow && !levelPrev;
      MODE_CHANGE: hit = changed;
      default:     hit = 1'b1;  // IMMEDIATE fires on the first ARMED cycle
    endcase
  end

  always_ff @(posedge crystalClk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      wrPtr     <= '0;
      fill      <= '0;
      postLeft  <= '0;
      trigAddr  <= '0;
      preCfg    <= '0;
      modeCfg   <= MODE_LEVEL;
      valueCfg  <= '0;
      maskCfg   <= '0;
      trigPrev  <= '0;
      triggered <= 1'b0;
    end else begin
      trigPrev <= trigIn;
      if (abort) begin
        state     <= S_IDLE;
        triggered <= 1'b0;
      end else if (armAccept) begin
        // preTrigDepth is ADDR_W wide, so it can never exceed DEPTH-1.
        preCfg    <= preTrigDepth;
        modeCfg   <= trigMode;
        valueCfg  <= trigValue;
        maskCfg   <= trigMask;
        triggered <= 1'b0;
        wrPtr     <= '0;
        fill      <= '0;
        state     <= (preTrigDepth == '0) ? S_ARMED : S_PRE;
      end else begin
        if (writing) wrPtr <= wrPtr + ADDR_W'(1);
        case (state)
          S_PRE: begin
            fill <= fill + ADDR_W'(1);
            if (fill + ADDR_W'(1) == preCfg) state <= S_ARMED;
          end
          S_ARMED: begin
            if (hit) begin
              trigAddr  <= wrPtr;
              triggered <= 1'b1;
              postLeft  <= LAST_IDX - preCfg;
              state     <= (preCfg == LAST_IDX) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            postLeft <= postLeft - ADDR_W'(1);
            if (postLeft == ADDR_W'(1)) state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge crystalClk or negedge rstN) begin
    if (!rstN) rd.rdValid <= 1'b0;
    else       rd.rdValid <= rdAccept;
  end

  la_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk    (crystalClk),
    .rstN   (rstN),
    .wrEn   (writing),
    .wrAddr (wrPtr),
    .wrData (dataIn),
    .rdEn   (rdAccept),
    .rdAddr (rdAddr),
    .rdData (rd.rdData)
  );

  assign captureState = state;
  assign armed        = (state == S_PRE) || (state == S_ARMED);
  assign done         = (state == S_DONE);
  assign trigIndex    = preCfg;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core at DEPTH=16: directed trigger scenarios plus
// randomized captures, checked against a timeline model of each capture.
module tb_la_capture_core;

  localparam int DW    = 48;
  localparam int TW    = 22;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          crystalClk = 1'b0;
  logic          rstN = 1'b0;
  logic          arm, abort;
  logic [1:0]    trigMode;
  logic [TW-1:0] trigValue, trigMask, trigIn;
  logic [AW-1:0] preTrigDepth;
  logic [DW-1:0] dataIn;
  logic [2:0]    captureState;
  logic          armed, triggered, done;
  logic [AW-1:0] trigIndex;

  la_capture_core_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) rdBus ();

  la_capture_core #(.DATA_WIDTH(DW), .TRIG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .crystalClk   (crystalClk),
    .rstN         (rstN),
    .arm          (arm),
    .abort        (abort),
    .trigMode     (trigMode),
    .trigValue    (trigValue),
    .trigMask     (trigMask),
    .preTrigDepth (preTrigDepth),
    .dataIn       (dataIn),
    .trigIn       (trigIn),
    .captureState (captureState),
    .armed        (armed),
    .triggered    (triggered),
    .done         (done),
    .trigIndex    (trigIndex),
    .rd           (rdBus)
  );

  always #5 crystalClk = ~crystalClk;

  // ---------------- bench state ----------------
  int            nChecks = 0;
  int            nFail = 0;
  logic [1:0]    cfgMode;
  logic [TW-1:0] cfgValue, cfgMask;
  logic [AW-1:0] cfgPre;
  int            abortAt, rearmAt;
  logic [TW-1:0] stTrig[$];
  logic [DW-1:0] stData[$];
  logic [5:0]    obs[$], expObs[$];
  logic [AW-1:0] obsTidx;
  logic [DW-1:0] rdObs[$];
  logic          rdvObs[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] lastRdExp;
  int            mJt, mJd;
  logic          expDone;

  // ---------------- reference model ----------------
  function automatic logic model_hit(int j);
    logic [TW-1:0] cur, prev;
    logic lc, lp;
    cur  = stTrig[j];
    prev = stTrig[j-1];
    lc = (cur & cfgMask) == (cfgValue & cfgMask);
    lp = (prev & cfgMask) == (cfgValue & cfgMask);
    case (cfgMode)
      2'd0:    return lc;
      2'd1:    return lc && !lp;
      2'd2:    return ((cur ^ prev) & cfgMask) != '0;
      default: return 1'b1;
    endcase
  endfunction

  // Cycle j = 0 is the arm cycle; cycle j >= 1 writes sample stData[j].
  // Expected observation after cycle j is {state, armed, triggered, done}.
  task automatic model_capture();
    int post;
    post = DEPTH - 1 - int'(cfgPre);
    mJt = -1;
    for (int j = int'(cfgPre) + 1; j < stTrig.size(); j++) begin
      if (abortAt >= 0 && j >= abortAt) break;
      if (model_hit(j)) begin
        mJt = j;
        break;
      end
    end
    mJd = (mJt >= 0) ? mJt + post : -1;
    expDone = (mJt >= 0) && (mJd < stTrig.size()) && (abortAt < 0 || mJd < abortAt);
    expObs.delete();
    for (int j = 0; j < stTrig.size(); j++) begin
      if (abortAt >= 0 && j >= abortAt)  expObs.push_back({3'd0, 3'b000});
      else if (j < int'(cfgPre))         expObs.push_back({3'd1, 3'b100});
      else if (mJt < 0 || j < mJt)       expObs.push_back({3'd2, 3'b100});
      else if (j < mJd)                  expObs.push_back({3'd3, 3'b010});
      else                               expObs.push_back({3'd4, 3'b011});
    end
    exp_q.delete();
    if (expDone)
      for (int i = mJt - int'(cfgPre); i <= mJd; i++) exp_q.push_back(stData[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic run_capture();
    obs.delete();
    for (int j = 0; j < stTrig.size(); j++) begin
      @(negedge crystalClk);
      arm   = (j == 0) || (j == rearmAt);
      abort = (j == abortAt);
      if (j == 0) begin
        trigMode = cfgMode; trigValue = cfgValue; trigMask = cfgMask; preTrigDepth = cfgPre;
      end else begin
        trigMode = 2'($urandom); trigValue = TW'($urandom);
        trigMask = TW'($urandom); preTrigDepth = AW'($urandom);
      end
      trigIn = stTrig[j];
      dataIn = stData[j];
      @(posedge crystalClk); #1;
      obs.push_back({captureState, armed, triggered, done});
    end
    obsTidx = trigIndex;
    @(negedge crystalClk);
    arm = 1'b0;
    abort = 1'b0;
  endtask

  task automatic read_all();
    rdObs.delete();
    rdvObs.delete();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge crystalClk);
      rdBus.rdEn  = 1'b1;
      rdBus.rdIdx = AW'(i);
      @(posedge crystalClk); #1;
      rdObs.push_back(rdBus.rdData);
      rdvObs.push_back(rdBus.rdValid);
    end
    @(negedge crystalClk);
    rdBus.rdEn = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(posedge crystalClk);
    #1;
    nChecks++;
    if ({captureState, armed, triggered, done, rdBus.rdValid} !== 7'b0) begin
      nFail++;
      $display("FAIL reset_status got=%b exp=%b", {captureState, armed, triggered, done, rdBus.rdValid}, 7'b0);
    end
    nChecks++;
    if (trigIndex !== '0 || rdBus.rdData !== '0) begin
      nFail++;
      $display("FAIL reset_regs trigIndex=%0d rdData=%h exp both 0", trigIndex, rdBus.rdData);
    end
    @(negedge crystalClk);
    rstN = 1'b1;
    @(negedge crystalClk);
    rdBus.rdEn  = 1'b1;
    rdBus.rdIdx = AW'($urandom);
    @(posedge crystalClk); #1;
    nChecks++;
    if (rdBus.rdValid !== 1'b0 || rdBus.rdData !== '0) begin
      nFail++;
      $display("FAIL reset_idle_read rdValid=%b rdData=%h exp 0/0", rdBus.rdValid, rdBus.rdData);
    end
    @(negedge crystalClk);
    rdBus.rdEn = 1'b0;
  endtask

  task automatic test_level();
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 42; j++) begin
      stTrig.push_back(TW'(5 + j));
      stData.push_back(DW'(5 + j));
    end
    cfgMode = 2'd0; cfgMask = 22'h3FFFFF; cfgValue = 22'h000020; cfgPre = 4'd4;
    abortAt = -1; rearmAt = 3;
    model_capture();
    run_capture();
    nChecks++;
    if (obsTidx !== cfgPre) begin
      nFail++; $display("FAIL level_trigIndex got=%0d exp=%0d", obsTidx, cfgPre);
    end
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL level_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
        nFail++; $display("FAIL level_read idx=%0d got=%b/%h exp=1/%h", i, rdvObs[i], rdObs[i], exp_q[i]);
      end
    end
    nChecks++;
    if (rdObs[0] !== 48'h1C || rdObs[DEPTH-1] !== 48'h2B) begin
      nFail++; $display("FAIL level_window got=%h..%h exp=1c..2b", rdObs[0], rdObs[DEPTH-1]);
    end
  endtask

  task automatic test_edge();
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 25; j++) begin
      stTrig.push_back((TW'($urandom) & ~TW'(1)) | TW'(j != 6));
      stData.push_back({16'($urandom), 32'($urandom)});
    end
    cfgMode = 2'd1; cfgMask = 22'h1; cfgValue = 22'h1; cfgPre = 4'd0;
    abortAt = -1; rearmAt = -1;
    model_capture();
    run_capture();
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL edge_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
        nFail++; $display("FAIL edge_read idx=%0d got=%b/%h exp=1/%h", i, rdvObs[i], rdObs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_change();
    logic [TW-1:0] fixedBits;
    fixedBits = TW'($urandom) & 22'h0F0;
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 30; j++) begin
      stTrig.push_back((TW'($urandom) & ~22'h0F0) | ((j >= 10) ? (fixedBits ^ 22'h020) : fixedBits));
      stData.push_back({16'($urandom), 32'($urandom)});
    end
    cfgMode = 2'd2; cfgMask = 22'h0F0; cfgValue = TW'($urandom); cfgPre = 4'd2;
    abortAt = -1; rearmAt = -1;
    model_capture();
    run_capture();
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL change_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
        nFail++; $display("FAIL change_read idx=%0d got=%b/%h exp=1/%h", i, rdvObs[i], rdObs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_immediate();
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 20; j++) begin
      stTrig.push_back(TW'($urandom));
      stData.push_back({16'($urandom), 32'($urandom)});
    end
    cfgMode = 2'd3; cfgMask = TW'($urandom); cfgValue = TW'($urandom); cfgPre = 4'd15;
    abortAt = -1; rearmAt = -1;
    model_capture();
    run_capture();
    nChecks++;
    if (obsTidx !== 4'd15) begin
      nFail++; $display("FAIL imm_trigIndex got=%0d exp=15", obsTidx);
    end
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL imm_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
        nFail++; $display("FAIL imm_read idx=%0d got=%b/%h exp=1/%h", i, rdvObs[i], rdObs[i], exp_q[i]);
      end
    end
    nChecks++;
    if (rdObs[15] !== stData[16]) begin
      nFail++; $display("FAIL imm_trigger_sample got=%h exp=%h", rdObs[15], stData[16]);
    end
  endtask

  task automatic test_rearm();
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 20; j++) begin
      stTrig.push_back(TW'($urandom));
      stData.push_back({16'($urandom), 32'($urandom)});
    end
    cfgMode = 2'd3; cfgMask = TW'($urandom); cfgValue = TW'($urandom); cfgPre = 4'd0;
    abortAt = -1; rearmAt = -1;
    model_capture();
    run_capture();
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL rearm_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
        nFail++; $display("FAIL rearm_read idx=%0d got=%b/%h exp=1/%h", i, rdvObs[i], rdObs[i], exp_q[i]);
      end
    end
    nChecks++;
    if (rdObs[0] !== stData[1]) begin
      nFail++; $display("FAIL rearm_first_sample got=%h exp=%h", rdObs[0], stData[1]);
    end
    lastRdExp = exp_q[DEPTH-1];
  endtask

  task automatic test_abort();
    stTrig.delete(); stData.delete();
    for (int j = 0; j < 18; j++) begin
      stTrig.push_back(TW'(12'h100 + j));
      stData.push_back(DW'(12'h100 + j));
    end
    cfgMode = 2'd0; cfgMask = 22'h3FFFFF; cfgValue = 22'h00010A; cfgPre = 4'd3;
    abortAt = 15; rearmAt = 15;
    model_capture();
    run_capture();
    for (int j = 0; j < obs.size(); j++) begin
      nChecks++;
      if (obs[j] !== expObs[j]) begin
        nFail++; $display("FAIL abort_cycle j=%0d got=%b exp=%b", j, obs[j], expObs[j]);
      end
    end
    @(negedge crystalClk);
    rdBus.rdEn  = 1'b1;
    rdBus.rdIdx = AW'($urandom);
    @(posedge crystalClk); #1;
    nChecks++;
    if (rdBus.rdValid !== 1'b0 || rdBus.rdData !== lastRdExp) begin
      nFail++; $display("FAIL abort_read got=%b/%h exp=0/%h", rdBus.rdValid, rdBus.rdData, lastRdExp);
    end
    @(negedge crystalClk);
    rdBus.rdEn = 1'b0;
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 10; r++) begin
      cfgMode  = 2'($urandom_range(0, 3));
      cfgMask  = TW'($urandom_range(1, 7));
      cfgValue = TW'($urandom);
      cfgPre   = AW'($urandom_range(0, DEPTH - 1));
      len = int'(cfgPre) + 1 + 30 + DEPTH;
      stTrig.delete(); stData.delete();
      for (int j = 0; j < len; j++) begin
        stTrig.push_back(TW'($urandom));
        stData.push_back({16'($urandom), 32'($urandom)});
      end
      abortAt = -1; rearmAt = -1;
      model_capture();
      if (!expDone) begin
        abortAt = len - 1;
        model_capture();
      end
      rearmAt = expDone ? int'($urandom_range(1, mJd)) : int'($urandom_range(1, abortAt - 1));
      run_capture();
      nChecks++;
      if (obsTidx !== cfgPre) begin
        nFail++; $display("FAIL rand_trigIndex run=%0d got=%0d exp=%0d", r, obsTidx, cfgPre);
      end
      for (int j = 0; j < obs.size(); j++) begin
        nChecks++;
        if (obs[j] !== expObs[j]) begin
          nFail++; $display("FAIL rand_cycle run=%0d j=%0d got=%b exp=%b", r, j, obs[j], expObs[j]);
        end
      end
      if (expDone) begin
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
          nChecks++;
          if (rdvObs[i] !== 1'b1 || rdObs[i] !== exp_q[i]) begin
            nFail++; $display("FAIL rand_read run=%0d idx=%0d got=%b/%h exp=1/%h", r, i, rdvObs[i], rdObs[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    arm = 1'b0; abort = 1'b0; trigMode = 2'd0; trigValue = '0; trigMask = '0;
    preTrigDepth = '0; dataIn = '0; trigIn = '0;
    rdBus.rdEn = 1'b0; rdBus.rdIdx = '0;
    lastRdExp = '0;
    test_reset();
    test_level();
    test_edge();
    test_change();
    test_immediate();
    test_rearm();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
